// File: rtl/quad_mixer_slew.sv
// Quad-X motor mixer: throttle/yaw/roll/pitch rates -> four clamped, slew-limited, rounded motor rates.
// Latency: accept at E0, motor rates/sat_flags update at E5, motor_valid pulses the cycle after E5.
// Backpressure: rates_ready is high only in IDLE; one set accepted per 6 cycles at most.
//
// Ports:
//   sys_clk, reset (async, active-high)
//   arm, rates_valid / rates_ready, yaw_rate, roll_rate, pitch_rate, throttle_rate (signed fixed point)
//   motor_1_rate..motor_4_rate (unsigned integer part, rounded), motor_valid, sat_flags[3:0]
module quad_mixer_slew #(
    parameter int RATE_WIDTH  = 16,
    parameter int FRAC_BITS   = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int YAW_SHIFT   = 1,
    parameter int ROLL_SHIFT  = 1,
    parameter int PITCH_SHIFT = 1,
    parameter int MOTOR_MIN   = 160,
    parameter int MOTOR_MAX   = 4000,
    parameter int SLEW_STEP   = 64
) (
    input  logic                         sys_clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         rates_valid,
    output logic                         rates_ready,
    input  logic signed [RATE_WIDTH-1:0] yaw_rate,
    input  logic signed [RATE_WIDTH-1:0] roll_rate,
    input  logic signed [RATE_WIDTH-1:0] pitch_rate,
    input  logic signed [RATE_WIDTH-1:0] throttle_rate,
    output logic [OUT_WIDTH-1:0]         motor_1_rate,
    output logic [OUT_WIDTH-1:0]         motor_2_rate,
    output logic [OUT_WIDTH-1:0]         motor_3_rate,
    output logic [OUT_WIDTH-1:0]         motor_4_rate,
    output logic                         motor_valid,
    output logic [3:0]                   sat_flags
);

    // Two guard bits: a sum of four sign-extended RATE_WIDTH terms can never wrap.
    localparam int MW = RATE_WIDTH + 2;
    typedef logic signed [MW-1:0] mix_t;

    localparam mix_t MIN_F  = mix_t'(MOTOR_MIN);
    localparam mix_t MAX_F  = mix_t'(MOTOR_MAX);
    localparam mix_t STEP_F = mix_t'(SLEW_STEP);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCALE = 3'd1;
    localparam logic [2:0] S_MIX   = 3'd2;
    localparam logic [2:0] S_CLAMP = 3'd3;
    localparam logic [2:0] S_SLEW  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0] state;

    logic signed [RATE_WIDTH-1:0] t_q, y_q, r_q, p_q;
    logic signed [RATE_WIDTH-1:0] ys_q, rs_q, ps_q;
    logic                         arm_q;
    logic                         gate_q;
    logic [3:0]                   flags_q;
    mix_t mix_q  [4];
    mix_t tgt_q  [4];
    mix_t app_q  [4];
    mix_t prev_q [4];

    mix_t                 mix_d  [4];
    mix_t                 tgt_d  [4];
    mix_t                 app_d  [4];
    logic [3:0]           flags_d;
    logic                 gate_d;
    logic [OUT_WIDTH-1:0] out_d  [4];

    assign rates_ready = (state == S_IDLE);

    function automatic mix_t sext(input logic signed [RATE_WIDTH-1:0] v);
        return {{2{v[RATE_WIDTH-1]}}, v};
    endfunction

    // Integer part plus half-LSB rounding; anything that would not fit saturates to all ones.
    function automatic logic [OUT_WIDTH-1:0] to_out(input mix_t v);
        logic [OUT_WIDTH-1:0] hi;
        logic                 rb;
        logic                 ovf;
        hi  = v[FRAC_BITS+OUT_WIDTH-1:FRAC_BITS];
        rb  = v[FRAC_BITS-1];
        ovf = |v[MW-1:FRAC_BITS+OUT_WIDTH];
        if (ovf || (rb && (&hi))) return {OUT_WIDTH{1'b1}};
        return hi + {{(OUT_WIDTH-1){1'b0}}, rb};
    endfunction

    always_comb begin
        mix_t tx, yx, rx, px;
        tx = sext(t_q);
        yx = sext(ys_q);
        rx = sext(rs_q);
        px = sext(ps_q);
        mix_d[0] = tx - yx + rx + px;
        mix_d[1] = tx + yx - rx + px;
        mix_d[2] = tx - yx - rx - px;
        mix_d[3] = tx + yx + rx - px;
    end

    // Disarmed or idle throttle forces all motors off and skips clamping.
    always_comb begin
        gate_d  = !arm_q || (sext(t_q) <= MIN_F);
        flags_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tgt_d[i] = mix_q[i];
            if (gate_d) begin
                tgt_d[i] = '0;
            end else if (mix_q[i] < MIN_F) begin
                tgt_d[i]   = MIN_F;
                flags_d[i] = 1'b1;
            end else if (mix_q[i] > MAX_F) begin
                tgt_d[i]   = MAX_F;
                flags_d[i] = 1'b1;
            end
        end
    end

    // A zero previous value means the motor was stopped: ramp from MOTOR_MIN.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mix_t base, diff;
            base     = (prev_q[i] == '0) ? MIN_F : prev_q[i];
            diff     = tgt_q[i] - base;
            app_d[i] = tgt_q[i];
            if (gate_q) begin
                app_d[i] = '0;
            end else if (SLEW_STEP > 0) begin
                if (diff > STEP_F)       app_d[i] = base + STEP_F;
                else if (diff < -STEP_F) app_d[i] = base - STEP_F;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) out_d[i] = to_out(app_q[i]);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            t_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            p_q          <= '0;
            ys_q         <= '0;
            rs_q         <= '0;
            ps_q         <= '0;
            arm_q        <= 1'b0;
            gate_q       <= 1'b0;
            flags_q      <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                mix_q[i]  <= '0;
                tgt_q[i]  <= '0;
                app_q[i]  <= '0;
                prev_q[i] <= '0;
            end
            motor_1_rate <= '0;
            motor_2_rate <= '0;
            motor_3_rate <= '0;
            motor_4_rate <= '0;
            motor_valid  <= 1'b0;
            sat_flags    <= 4'b0000;
        end else begin
            motor_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rates_valid) begin
                        t_q   <= throttle_rate;
                        y_q   <= yaw_rate;
                        r_q   <= roll_rate;
                        p_q   <= pitch_rate;
                        arm_q <= arm;
                        state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    ys_q  <= y_q >>> YAW_SHIFT;
                    rs_q  <= r_q >>> ROLL_SHIFT;
                    ps_q  <= p_q >>> PITCH_SHIFT;
                    state <= S_MIX;
                end
                S_MIX: begin
                    for (int i = 0; i < 4; i++) mix_q[i] <= mix_d[i];
                    state <= S_CLAMP;
                end
                S_CLAMP: begin
                    for (int i = 0; i < 4; i++) tgt_q[i] <= tgt_d[i];
                    gate_q  <= gate_d;
                    flags_q <= flags_d;
                    state   <= S_SLEW;
                end
                S_SLEW: begin
                    for (int i = 0; i < 4; i++) begin
                        app_q[i]  <= app_d[i];
                        prev_q[i] <= app_d[i];
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    motor_1_rate <= out_d[0];
                    motor_2_rate <= out_d[1];
                    motor_3_rate <= out_d[2];
                    motor_4_rate <= out_d[3];
                    sat_flags    <= flags_q;
                    motor_valid  <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    motor_1_rate <= '0;
                    motor_2_rate <= '0;
                    motor_3_rate <= '0;
                    motor_4_rate <= '0;
                    sat_flags    <= 4'b0000;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_mixer_slew.sv
module tb_quad_mixer_slew;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        valid;
    logic [15:0] t, y, r, p;

    logic       ready0, mv0;
    logic [7:0] m0_1, m0_2, m0_3, m0_4;
    logic [3:0] sat0;
    logic       ready1, mv1;
    logic [7:0] m1_1, m1_2, m1_3, m1_4;
    logic [3:0] sat1;

    int n_cmp;
    int n_fail;

    quad_mixer_slew #(.SLEW_STEP(0)) dut0 (
        .sys_clk(clk), .reset(rst), .arm(arm), .rates_valid(valid), .rates_ready(ready0),
        .yaw_rate(y), .roll_rate(r), .pitch_rate(p), .throttle_rate(t),
        .motor_1_rate(m0_1), .motor_2_rate(m0_2), .motor_3_rate(m0_3), .motor_4_rate(m0_4),
        .motor_valid(mv0), .sat_flags(sat0)
    );

    quad_mixer_slew dut1 (
        .sys_clk(clk), .reset(rst), .arm(arm), .rates_valid(valid), .rates_ready(ready1),
        .yaw_rate(y), .roll_rate(r), .pitch_rate(p), .throttle_rate(t),
        .motor_1_rate(m1_1), .motor_2_rate(m1_2), .motor_3_rate(m1_3), .motor_4_rate(m1_4),
        .motor_valid(mv1), .sat_flags(sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one set and returns the number of edges from acceptance to the motor_valid pulse
    // (10 means the pulse never came).
    task automatic run_set(input logic [15:0] tt, input logic [15:0] yy, input logic [15:0] rr,
                           input logic [15:0] pp, input logic aa, output int lat);
        int guard;
        guard = 0;
        while (ready0 !== 1'b1 && guard < 12) begin
            @(posedge clk); #1;
            guard++;
        end
        t = tt; y = yy; r = rr; p = pp; arm = aa; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        while (mv0 !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, m1_1, m1_2, m1_3, m1_4} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rates: got %h %h %h %h / %h %h %h %h, want all 0",
                     m0_1, m0_2, m0_3, m0_4, m1_1, m1_2, m1_3, m1_4);
        end
        n_cmp++;
        if ({mv0, mv1, ready0, ready1, sat0, sat1} !== 12'b0011_0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: mv %b%b ready %b%b sat %b %b, want mv 00 ready 11 sat 0",
                     mv0, mv1, ready0, ready1, sat0, sat1);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_set(16'd1600, 16'd0, 16'd0, 16'd0, 1'b1, lat);
        n_cmp++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges after accept, want 5", lat);
        end
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== {8'd100, 8'd100, 8'd100, 8'd100, 4'b0000}) begin
            n_fail++;
            $display("FAIL basic_rates: got %0d %0d %0d %0d sat %b, want 100 x4 sat 0000",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({mv0, ready0} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_pulse: mv %b ready %b one cycle later, want mv 0 ready 1", mv0, ready0);
        end
        n_cmp++;
        if (m0_1 !== 8'd100) begin
            n_fail++;
            $display("FAIL basic_hold: got %0d, want 100", m0_1);
        end
    endtask

    task automatic test_roll_round();
        int lat;
        run_set(16'd1600, 16'd0, 16'd320, 16'd0, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4} !== {8'd110, 8'd90, 8'd90, 8'd110}) begin
            n_fail++;
            $display("FAIL roll_mix: got %0d %0d %0d %0d, want 110 90 90 110", m0_1, m0_2, m0_3, m0_4);
        end
        run_set(16'd1608, 16'd0, 16'd0, 16'd0, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4} !== {4{8'd101}}) begin
            n_fail++;
            $display("FAIL round_up: got %0d %0d %0d %0d, want 101 x4", m0_1, m0_2, m0_3, m0_4);
        end
    endtask

    task automatic test_saturation();
        int lat;
        run_set(16'd3920, 16'd0, 16'd0, 16'd640, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== {8'd250, 8'd250, 8'd225, 8'd225, 4'b0011}) begin
            n_fail++;
            $display("FAIL sat_max: got %0d %0d %0d %0d sat %b, want 250 250 225 225 sat 0011",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
        run_set(16'd1600, 16'h8000, 16'h8000, 16'h8000, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== {8'd10, 8'd10, 8'd250, 8'd10, 4'b1111}) begin
            n_fail++;
            $display("FAIL sat_nowrap: got %0d %0d %0d %0d sat %b, want 10 10 250 10 sat 1111",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
    endtask

    task automatic test_gate();
        int lat;
        run_set(16'd1600, 16'd0, 16'd320, 16'd0, 1'b0, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== 36'h0) begin
            n_fail++;
            $display("FAIL gate_disarm: got %0d %0d %0d %0d sat %b, want 0 x4 sat 0000",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
        run_set(16'd160, 16'd0, 16'd0, 16'd640, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== 36'h0) begin
            n_fail++;
            $display("FAIL gate_min_throttle: got %0d %0d %0d %0d sat %b, want 0 x4 sat 0000",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
        run_set(16'd176, 16'd0, 16'd0, 16'd0, 1'b1, lat);
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0} !== {{4{8'd11}}, 4'b0000}) begin
            n_fail++;
            $display("FAIL gate_above_min: got %0d %0d %0d %0d sat %b, want 11 x4 sat 0000",
                     m0_1, m0_2, m0_3, m0_4, sat0);
        end
    endtask

    task automatic test_slew();
        int lat;
        int fix;
        logic [7:0] e;
        apply_reset();
        for (int i = 0; i < 23; i++) begin
            run_set(16'd1600, 16'd0, 16'd0, 16'd0, 1'b1, lat);
            fix = 160 + 64 * (i + 1);
            if (fix > 1600) fix = 1600;
            e = 8'(fix / 16);
            n_cmp++;
            if ({m1_1, m1_2, m1_3, m1_4, sat1} !== {{4{e}}, 4'b0000}) begin
                n_fail++;
                $display("FAIL slew_step%0d: got %0d %0d %0d %0d sat %b, want %0d x4 sat 0000",
                         i, m1_1, m1_2, m1_3, m1_4, sat1, e);
            end
        end
        run_set(16'd1600, 16'd0, 16'd0, 16'd0, 1'b0, lat);
        n_cmp++;
        if ({m1_1, m1_2, m1_3, m1_4} !== 32'h0) begin
            n_fail++;
            $display("FAIL slew_disarm: got %0d %0d %0d %0d, want 0 x4", m1_1, m1_2, m1_3, m1_4);
        end
        run_set(16'd1600, 16'd0, 16'd0, 16'd0, 1'b1, lat);
        n_cmp++;
        if ({m1_1, m1_2, m1_3, m1_4} !== {4{8'd14}}) begin
            n_fail++;
            $display("FAIL slew_rearm: got %0d %0d %0d %0d, want 14 x4", m1_1, m1_2, m1_3, m1_4);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cnt, first_acc, last_acc, pulses;
        acc_cnt = 0; first_acc = -1; last_acc = -1; pulses = 0;
        @(posedge clk); #1;
        t = 16'd1600; y = 16'd0; r = 16'd0; p = 16'd0; arm = 1'b1; valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (ready0 === 1'b1) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                acc_cnt++;
            end
            if (mv0 === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        n_cmp++;
        if (acc_cnt !== 4 || (last_acc - first_acc) !== 18) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d accepts spanning %0d cycles, want 4 spanning 18",
                     acc_cnt, last_acc - first_acc);
        end
        n_cmp++;
        if (pulses !== 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d motor_valid pulses, want 3", pulses);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int lat;
        int pulses;
        run_set(16'd1600, 16'd0, 16'd0, 16'd0, 1'b1, lat);
        @(posedge clk); #1;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({m0_1, m0_2, m0_3, m0_4, sat0, mv0, ready0} !== {36'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midop_reset: got %0d %0d %0d %0d sat %b mv %b ready %b, want 0 x4 sat 0 mv 0 ready 1",
                     m0_1, m0_2, m0_3, m0_4, sat0, mv0, ready0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (mv0 === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || ready0 !== 1'b1 || m0_1 !== 8'd0) begin
            n_fail++;
            $display("FAIL midop_discard: pulses %0d ready %b m1 %0d, want pulses 0 ready 1 m1 0",
                     pulses, ready0, m0_1);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; arm = 1'b0; valid = 1'b0;
        t = '0; y = '0; r = '0; p = '0;
        test_reset();
        test_basic();
        test_roll_round();
        test_saturation();
        test_gate();
        test_back_to_back();
        test_reset_midop();
        test_slew();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_mixer_slew.md
# quad_mixer_slew

Parametrised, handshaked successor to the motor mixer: converts throttle/yaw/roll/pitch rate commands into four saturated, slew-limited, rounded motor rates for the PWM generators. It sits between the PID rate controllers and the pwm_generator instances. Compared with the previous mixer it adds generic widths and shifts, an accept/ready handshake, arming, per-update slew limiting, overflow-safe mixing and saturation flags.

## Interface
- RATE_WIDTH, 16: width of signed fixed-point rate inputs.
- FRAC_BITS, 4: fractional bits in rate inputs.
- OUT_WIDTH, 8: width of unsigned motor rate outputs.
- YAW_SHIFT / ROLL_SHIFT / PITCH_SHIFT, 1 / 1 / 1: arithmetic right shift applied to each axis.
- MOTOR_MIN, 160: minimum running rate, RATE_WIDTH fixed point (10.0).
- MOTOR_MAX, 4000: maximum rate, RATE_WIDTH fixed point (250.0).
- SLEW_STEP, 64: max change per motor per update, fixed point (4.0); 0 disables slew limiting.
- sys_clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  motors permitted to run; sampled with inputs.
- rates_valid  in  1  input rates valid.
- rates_ready  out  1  block can accept a new set.
- yaw_rate, roll_rate, pitch_rate, throttle_rate  in  RATE_WIDTH each  signed fixed point.
- motor_1_rate..motor_4_rate  out  OUT_WIDTH each  unsigned motor command.
- motor_valid  out  1  one-cycle pulse: new motor rates presented.
- sat_flags  out  4  bit n-1 set if motor n was clamped (MIN or MAX) in the latest update.

## Operation
- Mixing (quad X): M1 = T - Y + R + P; M2 = T + Y - R + P; M3 = T - Y - R - P; M4 = T + Y + R - P; Y/R/P are the shifted (>>>, sign-preserving) inputs.
- Mix arithmetic is RATE_WIDTH+2 bits signed, inputs sign-extended; no wrap-around for any input combination.
- Gate: if arm=0 or throttle <= MOTOR_MIN, all four targets = 0, slew bypassed, previous-value registers cleared, sat_flags = 0.
- Otherwise clamp each target to [MOTOR_MIN, MOTOR_MAX]; set corresponding sat_flags bit if clamped.
- Slew (SLEW_STEP>0): prev = last applied value (MOTOR_MIN substituted if prev = 0); delta = target - prev limited to ±SLEW_STEP; applied = prev + delta; stored as new prev. Slew limiting does not set sat_flags.
- Output: bits [FRAC_BITS+OUT_WIDTH-1:FRAC_BITS] plus round bit [FRAC_BITS-1]; if rounding overflows, output saturates to all ones.
- FSM: IDLE -> SCALE -> MIX -> CLAMP -> SLEW -> OUT -> IDLE. rates_ready = 1 only in IDLE. Transfer occurs on an edge with rates_valid & rates_ready; inputs and arm captured there; later input changes are ignored.

## Timing
- Reset: state IDLE, rates_ready = 1, motor_n_rate = 0, motor_valid = 0, sat_flags = 0, all internal and prev registers 0.
- Accept at edge E0; motor rates and sat_flags update at edge E5; motor_valid high for the cycle following E5 only; rates_ready high again after E5 (state IDLE).
- Max throughput: one set per 6 cycles; back-to-back valid accepted on the first cycle ready returns.
- Outputs hold between updates.
- Reset asserted mid-operation: immediate return to reset values; the in-flight set is discarded, no motor_valid.
- Unknown state encoding: treated as reset of outputs, next state IDLE.

## Test plan
- Reset, then release -> all rates 0, motor_valid 0, rates_ready 1, sat_flags 0.
- SLEW_STEP=0, arm=1, T=1600 (100.0), Y=R=P=0 -> after 6 edges all motors 100, motor_valid one-cycle pulse, sat_flags 0.
- SLEW_STEP=0, arm=1, T=1600, R=320 (20.0) -> M1=110, M2=90, M3=90, M4=110; T=1608 (100.5), others 0 -> all 101 (round up).
- SLEW_STEP=0, T=3920 (245.0), P=640 (40.0) -> M1=M2=250, M3=M4=225, sat_flags=4'b0011; Y=-32768, R=-32768, P=-32768, T=1600 -> no wrap: M3=250, clamp flags consistent.
- Default SLEW_STEP=64 from reset, T=1600 repeated -> M1..M4 = 14, 18, 22, ... rising 4 per update until 100; then arm=0 -> next update all 0 immediately.
- Hold rates_valid high continuously -> accepts exactly every 6 cycles; assert reset at cycle 3 of a transfer -> outputs 0, no motor_valid pulse, ready 1 after release.
